// File: rtl/transpose_row_serializer_if.sv
// Handshake bundle between the transpose switch network, the row serializer and
// the memory-group write path: a whole-matrix input channel and a row output channel.
interface transpose_row_serializer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8,
    parameter int NUM_MG     = 8
);
    localparam int CHUNK_WIDTH = NUM_MG / NUM_PE * DATA_WIDTH;
    localparam int IDX_W       = $clog2(NUM_PE);

    logic                                            in_valid;
    logic                                            in_ready;
    logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0]  in_elements;
    logic                                            out_valid;
    logic                                            out_ready;
    logic [0:NUM_PE-1][CHUNK_WIDTH-1:0]              out_row;
    logic [IDX_W-1:0]                                out_row_idx;
    logic                                            out_last;

    modport master (
        output in_valid, in_elements, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx, out_last
    );

    modport slave (
        input  in_valid, in_elements, out_ready,
        output in_ready, out_valid, out_row, out_row_idx, out_last
    );
endinterface

// File: rtl/transpose_row_serializer.sv
// Buffers a transposed NUM_PE x NUM_PE chunk matrix and streams it out one row per cycle.
// Define XPOSE_SER_DOUBLE_BUF_EN for a second bank so the next matrix loads while one drains.
module transpose_row_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8,
    parameter int NUM_MG     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    transpose_row_serializer_if.slave        bus,
    output logic                             busy
);
    localparam int CHUNK_WIDTH = NUM_MG / NUM_PE * DATA_WIDTH;
    localparam int IDX_W       = $clog2(NUM_PE);
`ifdef XPOSE_SER_DOUBLE_BUF_EN
    localparam int NUM_BANKS   = 2;
`else
    localparam int NUM_BANKS   = 1;
`endif

    typedef enum logic {BANK_EMPTY, BANK_FULL} bank_state_e;
    typedef logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0] matrix_t;

    bank_state_e      state_q [NUM_BANKS];
    bank_state_e      state_d [NUM_BANKS];
    matrix_t          data_q  [NUM_BANKS];
    matrix_t          data_d  [NUM_BANKS];
    logic [IDX_W-1:0] row_idx_q;
    logic [IDX_W-1:0] row_idx_d;
    logic             accept;
    logic             consume;
    logic             consume_last;
    logic             wr_sel;
    logic             rd_sel;

`ifdef XPOSE_SER_DOUBLE_BUF_EN
    // Banks fill and drain in strict alternation, so two toggling pointers suffice.
    logic wr_ptr_q;
    logic wr_ptr_d;
    logic rd_ptr_q;
    logic rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ accept;
        rd_ptr_d = rd_ptr_q ^ consume_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign wr_sel = wr_ptr_q;
    assign rd_sel = rd_ptr_q;
`else
    assign wr_sel = 1'b0;
    assign rd_sel = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= BANK_EMPTY;
                data_q[b]  <= '0;
            end
            row_idx_q <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= state_d[b];
                data_q[b]  <= data_d[b];
            end
            row_idx_q <= row_idx_d;
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            state_d[b] = state_q[b];
            data_d[b]  = data_q[b];
        end
        row_idx_d = row_idx_q;
        if (accept) begin
            state_d[wr_sel] = BANK_FULL;
            data_d[wr_sel]  = bus.in_elements;
        end
        // With two banks the write and read banks differ here, so both updates stand.
        if (consume_last) begin
            state_d[rd_sel] = BANK_EMPTY;
        end
        if (consume) begin
            row_idx_d = consume_last ? '0 : row_idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state_q[b] == BANK_EMPTY) begin
                bus.in_ready = 1'b1;
            end
            if (state_q[b] == BANK_FULL) begin
                busy = 1'b1;
            end
        end
        bus.out_valid   = (state_q[rd_sel] == BANK_FULL);
        bus.out_row     = data_q[rd_sel][row_idx_q];
        bus.out_row_idx = row_idx_q;
        bus.out_last    = bus.out_valid && (row_idx_q == IDX_W'(NUM_PE - 1));
        accept          = bus.in_valid && bus.in_ready;
        consume         = bus.out_valid && bus.out_ready;
        consume_last    = consume && bus.out_last;
    end
endmodule

// File: tb/tb_transpose_row_serializer.sv
// Directed bench for transpose_row_serializer; expectations follow XPOSE_SER_DOUBLE_BUF_EN
// when it is defined for the build.
module tb_transpose_row_serializer;
    localparam int DATA_WIDTH  = 64;
    localparam int NUM_PE      = 8;
    localparam int NUM_MG      = 8;
    localparam int CHUNK_WIDTH = NUM_MG / NUM_PE * DATA_WIDTH;
    localparam int IDX_W       = $clog2(NUM_PE);
`ifdef XPOSE_SER_DOUBLE_BUF_EN
    localparam int NUM_BANKS   = 2;
    localparam int B2B_ACCEPT  = 2;
    localparam int B2B_START   = 9;
`else
    localparam int NUM_BANKS   = 1;
    localparam int B2B_ACCEPT  = 9;
    localparam int B2B_START   = 10;
`endif

    typedef logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0] matrix_t;
    typedef logic [0:NUM_PE-1][CHUNK_WIDTH-1:0] row_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b1;
    logic busy;
    int   check_count = 0;
    int   pass_count  = 0;

    transpose_row_serializer_if #(
        .DATA_WIDTH(DATA_WIDTH), .NUM_PE(NUM_PE), .NUM_MG(NUM_MG)
    ) bus ();

    transpose_row_serializer #(
        .DATA_WIDTH(DATA_WIDTH), .NUM_PE(NUM_PE), .NUM_MG(NUM_MG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic matrix_t make_matrix(int base);
        matrix_t m;
        for (int j = 0; j < NUM_PE; j++)
            for (int k = 0; k < NUM_PE; k++)
                m[j][k] = CHUNK_WIDTH'(base + 16 * j + k);
        return m;
    endfunction

    function automatic row_t exp_row(int base, int j);
        row_t r;
        for (int k = 0; k < NUM_PE; k++) r[k] = CHUNK_WIDTH'(base + 16 * j + k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        check_count++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_last !== 1'b0)
            $display("[TB] FAIL por_state: ready/valid/busy/last=%b%b%b%b expected 1000",
                     bus.in_ready, bus.out_valid, busy, bus.out_last);
        else pass_count++;
        check_count++;
        if (bus.out_row !== '0 || bus.out_row_idx !== '0)
            $display("[TB] FAIL por_data: idx=%0d row=%h expected zeros", bus.out_row_idx, bus.out_row);
        else pass_count++;

        bus.in_valid = 1'b1;
        bus.in_elements = make_matrix(7000);
        tick();
        bus.in_valid = 1'b0;
        check_count++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b1)
            $display("[TB] FAIL preload: busy=%b valid=%b expected 1 1", busy, bus.out_valid);
        else pass_count++;

        // Stop the clock so only the asynchronous path can clear state.
        clk_en = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_count++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_row_idx !== '0)
            $display("[TB] FAIL async_reset: ready/valid/busy=%b%b%b idx=%0d expected 100 idx 0",
                     bus.in_ready, bus.out_valid, busy, bus.out_row_idx);
        else pass_count++;
        check_count++;
        if (bus.out_row !== '0)
            $display("[TB] FAIL async_reset_row: row=%h expected zeros", bus.out_row);
        else pass_count++;
        #3 rst = 1'b0;
        clk_en = 1'b1;
        tick();
        check_count++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL post_reset_idle: valid=%b busy=%b expected 0 0", bus.out_valid, busy);
        else pass_count++;
    endtask

    task automatic test_single_matrix();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_elements = make_matrix(0);
        tick();
        bus.in_valid = 1'b0;
        for (int r = 0; r < NUM_PE; r++) begin
            check_count++;
            if (bus.out_valid !== 1'b1 || bus.out_row_idx !== IDX_W'(r) || busy !== 1'b1)
                $display("[TB] FAIL single_ctl row%0d: valid=%b idx=%0d busy=%b expected 1 %0d 1",
                         r, bus.out_valid, bus.out_row_idx, busy, r);
            else pass_count++;
            check_count++;
            if (bus.out_row !== exp_row(0, r))
                $display("[TB] FAIL single_row%0d: got %h expected %h", r, bus.out_row, exp_row(0, r));
            else pass_count++;
            check_count++;
            if (bus.out_last !== (r == NUM_PE - 1))
                $display("[TB] FAIL single_last row%0d: got %b expected %b", r, bus.out_last, (r == NUM_PE - 1));
            else pass_count++;
`ifndef XPOSE_SER_DOUBLE_BUF_EN
            check_count++;
            if (bus.in_ready !== 1'b0)
                $display("[TB] FAIL single_inready row%0d: got %b expected 0", r, bus.in_ready);
            else pass_count++;
`endif
            tick();
        end
        check_count++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_last !== 1'b0)
            $display("[TB] FAIL single_done: valid/busy/ready/last=%b%b%b%b expected 0010",
                     bus.out_valid, busy, bus.in_ready, bus.out_last);
        else pass_count++;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_elements = make_matrix(100);
        tick();
        bus.in_valid = 1'b0;
        for (int r = 0; r < 3; r++) begin
            check_count++;
            if (bus.out_row_idx !== IDX_W'(r))
                $display("[TB] FAIL bp_pre row%0d: idx=%0d expected %0d", r, bus.out_row_idx, r);
            else pass_count++;
            tick();
        end
        // Row 3 is held for three stalled cycles, then taken on the fourth.
        for (int s = 0; s < 4; s++) begin
            bus.out_ready = (s == 3);
            check_count++;
            if (bus.out_valid !== 1'b1 || bus.out_row_idx !== IDX_W'(3) || bus.out_row !== exp_row(100, 3))
                $display("[TB] FAIL bp_hold s%0d: valid=%b idx=%0d row=%h expected 1 3 %h",
                         s, bus.out_valid, bus.out_row_idx, bus.out_row, exp_row(100, 3));
            else pass_count++;
            tick();
        end
        for (int r = 4; r < NUM_PE; r++) begin
            check_count++;
            if (bus.out_valid !== 1'b1 || bus.out_row_idx !== IDX_W'(r) || bus.out_row !== exp_row(100, r))
                $display("[TB] FAIL bp_post row%0d: valid=%b idx=%0d row=%h expected 1 %0d %h",
                         r, bus.out_valid, bus.out_row_idx, bus.out_row, r, exp_row(100, r));
            else pass_count++;
            tick();
        end
        check_count++;
        if (bus.out_valid !== 1'b0)
            $display("[TB] FAIL bp_done: valid=%b expected 0", bus.out_valid);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic exp_valid;
        int   exp_base;
        int   exp_idx;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_elements = make_matrix(0);
        tick();
        bus.in_valid = 1'b0;
        for (int c = 1; c <= B2B_START + NUM_PE; c++) begin
            if (c == 2) begin
                bus.in_valid = 1'b1;
                bus.in_elements = make_matrix(1000);
            end
            if (c >= 2 && c <= B2B_ACCEPT) begin
                check_count++;
                if (bus.in_ready !== (c == B2B_ACCEPT))
                    $display("[TB] FAIL b2b_ready c%0d: got %b expected %b", c, bus.in_ready, (c == B2B_ACCEPT));
                else pass_count++;
            end
            exp_valid = 1'b0;
            exp_base  = 0;
            exp_idx   = 0;
            if (c <= NUM_PE) begin
                exp_valid = 1'b1;
                exp_idx   = c - 1;
            end else if (c >= B2B_START && c < B2B_START + NUM_PE) begin
                exp_valid = 1'b1;
                exp_base  = 1000;
                exp_idx   = c - B2B_START;
            end
            check_count++;
            if (bus.out_valid !== exp_valid)
                $display("[TB] FAIL b2b_valid c%0d: got %b expected %b", c, bus.out_valid, exp_valid);
            else pass_count++;
            if (exp_valid) begin
                check_count++;
                if (bus.out_row_idx !== IDX_W'(exp_idx) || bus.out_row !== exp_row(exp_base, exp_idx))
                    $display("[TB] FAIL b2b_row c%0d: idx=%0d row=%h expected %0d %h",
                             c, bus.out_row_idx, bus.out_row, exp_idx, exp_row(exp_base, exp_idx));
                else pass_count++;
            end
            tick();
            if (c == B2B_ACCEPT) bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_full_ignore();
        bus.out_ready = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bus.in_valid = 1'b1;
            bus.in_elements = make_matrix(2000 + 1000 * b);
            tick();
        end
        bus.in_elements = make_matrix(9000);
        for (int s = 0; s < 3; s++) begin
            check_count++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b1)
                $display("[TB] FAIL full_ready s%0d: ready=%b busy=%b expected 0 1", s, bus.in_ready, busy);
            else pass_count++;
            check_count++;
            if (bus.out_row_idx !== '0 || bus.out_row !== exp_row(2000, 0))
                $display("[TB] FAIL full_hold s%0d: idx=%0d row=%h expected 0 %h",
                         s, bus.out_row_idx, bus.out_row, exp_row(2000, 0));
            else pass_count++;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int r = 0; r < NUM_PE; r++) begin
                check_count++;
                if (bus.out_valid !== 1'b1 || bus.out_row_idx !== IDX_W'(r) ||
                    bus.out_row !== exp_row(2000 + 1000 * b, r))
                    $display("[TB] FAIL full_drain b%0d row%0d: valid=%b idx=%0d row=%h expected %h",
                             b, r, bus.out_valid, bus.out_row_idx, bus.out_row, exp_row(2000 + 1000 * b, r));
                else pass_count++;
                tick();
            end
        end
        check_count++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL full_done: valid=%b busy=%b expected 0 0", bus.out_valid, busy);
        else pass_count++;
    endtask

    task automatic test_reset_mid_drain();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_elements = make_matrix(4000);
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        check_count++;
        if (bus.out_row_idx !== IDX_W'(4) || bus.out_valid !== 1'b1)
            $display("[TB] FAIL mid_pre: idx=%0d valid=%b expected 4 1", bus.out_row_idx, bus.out_valid);
        else pass_count++;
        #2 rst = 1'b1;
        #1;
        check_count++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_row_idx !== '0)
            $display("[TB] FAIL mid_reset: valid/busy/ready=%b%b%b idx=%0d expected 001 idx 0",
                     bus.out_valid, busy, bus.in_ready, bus.out_row_idx);
        else pass_count++;
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        check_count++;
        if (bus.out_valid !== 1'b0)
            $display("[TB] FAIL mid_stale: valid=%b expected 0", bus.out_valid);
        else pass_count++;
        bus.in_valid = 1'b1;
        bus.in_elements = make_matrix(5000);
        tick();
        bus.in_valid = 1'b0;
        for (int r = 0; r < NUM_PE; r++) begin
            check_count++;
            if (bus.out_valid !== 1'b1 || bus.out_row_idx !== IDX_W'(r) || bus.out_row !== exp_row(5000, r))
                $display("[TB] FAIL mid_new row%0d: valid=%b idx=%0d row=%h expected %h",
                         r, bus.out_valid, bus.out_row_idx, bus.out_row, exp_row(5000, r));
            else pass_count++;
            tick();
        end
        check_count++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL mid_done: valid=%b busy=%b expected 0 0", bus.out_valid, busy);
        else pass_count++;
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.in_elements = '0;
        $display("[TB] starting, banks=%0d", NUM_BANKS);
        test_reset();
        test_single_matrix();
        test_backpressure();
        test_back_to_back();
        test_full_ignore();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/transpose_row_serializer.md
# transpose_row_serializer

Drain-side companion to the matrix transpose switch network. It captures the network's full NUM_PE x NUM_PE chunk matrix in one cycle via a valid/ready handshake, buffers it, and streams it out one row per cycle over a second valid/ready handshake toward the memory-group write path. An optional second buffer bank lets the next transposed matrix be accepted while the current one drains, so rows stream without gaps.

## Interface
- DATA_WIDTH, 64, element width in bits
- NUM_PE, 8, rows/columns per matrix; power of two, at least 2
- NUM_MG, 8, memory groups; chunk width is CHUNK_WIDTH = NUM_MG / NUM_PE * DATA_WIDTH (derived localparam)
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  in_elements holds a complete transposed matrix
- in_ready  output  1  a free buffer bank is available
- in_elements  input  [CHUNK_WIDTH-1:0] [0:NUM_PE-1][0:NUM_PE-1]  matrix from the switch network, indexed [row][col]
- out_valid  output  1  out_row is valid
- out_ready  input  1  downstream accepts out_row this cycle
- out_row  output  [CHUNK_WIDTH-1:0] [0:NUM_PE-1]  current row
- out_row_idx  output  $clog2(NUM_PE)  index of out_row within its matrix
- out_last  output  1  out_row is row NUM_PE-1
- busy  output  1  at least one bank holds undrained data

## Operation
- Accept: in_valid && in_ready at a rising edge. Writes all of in_elements into the free bank and marks it full. The write bank alternates when double buffering is enabled.
- Emit: out_valid = read bank full. out_row = read_bank[out_row_idx], read combinationally from the registered storage, so it is stable while stalled.
- Advance: on out_valid && out_ready, out_row_idx increments.
  - At NUM_PE-1, out_row_idx wraps to 0, the read bank is marked empty, and the read pointer toggles (double buffer only).
- State per bank: EMPTY -> FULL on accept; FULL -> EMPTY on consumption of its last row.
- Rows are emitted in order 0..NUM_PE-1. No data reordering happens here; the transposition is done upstream.
- in_ready = any bank EMPTY. It is combinational from registered state and never depends on out_ready.
- Simultaneous accept and last-row consume on the same edge: both take effect.
  - Double buffer: no bubble; the other bank becomes the read bank.
  - Single bank: in_ready is low in that cycle, so no accept can coincide with the last-row consume.
- in_valid while in_ready = 0: ignored; the upstream source holds its data.
- Reset (async, any time, including mid-drain): all banks EMPTY, pointers and out_row_idx = 0. Buffered data is discarded.
- Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_row_idx = 0, busy = 0, out_row = all zeros (storage cleared).

## Timing
- Accept edge N: out_valid = 1 with row 0 from cycle N+1.
- Minimum drain: NUM_PE cycles with out_ready held high.
- Single bank: in_ready returns to 1 in the cycle after the last-row edge. Throughput is one matrix per NUM_PE+1 cycles.
- Double buffer: sustained throughput is one matrix per NUM_PE cycles. out_valid stays high across the matrix boundary.
- out_last = out_valid && out_row_idx == NUM_PE-1.
- Outputs hold while out_valid && !out_ready.

## Configuration
- XPOSE_SER_DOUBLE_BUF_EN defined: two banks with independent write and read pointers; next matrix accepted during drain.
- Not defined: a single bank; in_ready = !busy; the write and read pointers are removed.

## Test plan
- Reset: assert rst mid-simulation with no clock -> in_ready = 1, out_valid = 0, out_row_idx = 0, busy = 0 immediately.
- Single matrix, element [j][k] = 16*j + k, out_ready = 1, accept at edge N -> rows 0..7 on cycles N+1..N+8 with out_row[k] = 16*j + k; out_last only on row 7; busy low and in_ready high from cycle N+9.
- Backpressure: drop out_ready for 3 cycles while row 3 is presented -> out_row, out_row_idx = 3 and out_valid unchanged for those 3 cycles; row 4 follows on the first cycle after out_ready returns.
- Back-to-back, offer a second matrix (values +1000) at cycle N+2:
  - With XPOSE_SER_DOUBLE_BUF_EN: accepted at N+2; its row 0 appears at N+9 with no gap.
  - Without: in_ready stays 0 until N+9; second matrix accepted at N+9; its row 0 appears at N+10.
- Full-buffer ignore: with all banks full, drive in_valid with a distinct matrix -> no accept; the drained data matches only the earlier matrices.
- Reset mid-drain at row 4 -> out_valid falls asynchronously, busy = 0; after release, a new matrix drains starting at row 0 with no stale rows.
